// File: rtl/io_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_pkg : register map, CTRL bit indices and access-FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package io_pkg;

    localparam logic [2:0] OFF_DBG_OUT    = 3'd0;
    localparam logic [2:0] OFF_BTN_STATUS = 3'd1;
    localparam logic [2:0] OFF_LED_X      = 3'd2;
    localparam logic [2:0] OFF_LED_Y      = 3'd3;
    localparam logic [2:0] OFF_EVENT      = 3'd4;
    localparam logic [2:0] OFF_CTRL       = 3'd5;
    localparam logic [7:0] NUM_REGS       = 8'd6;

    localparam int CTRL_AUTO_STEP = 0;
    localparam int CTRL_IRQ_EN    = 1;

    typedef logic [1:0] acc_state_t;
    localparam acc_state_t ST_IDLE    = 2'd0;
    localparam acc_state_t ST_ACCESS  = 2'd1;
    localparam acc_state_t ST_RELEASE = 2'd2;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_controller_if : CPU I/O cycle bus between the CPU side and io_controller
// Revision: 1.0
// ---------------------------------------------------------------------------
interface io_controller_if;
    logic       mem_clk;
    logic       mem_io;
    logic       io_we;
    logic       io_oe;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output mem_clk, mem_io, io_we, io_oe, addr, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  mem_clk, mem_io, io_we, io_oe, addr, data_in,
        output data_out, data_oe
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_debounce : 2-flop synchroniser, stability counter, rising-edge pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_rise
);

    localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // The pulse is registered together with the level so both appear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= r_s2;
                    r_rise  <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/io_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_controller : memory-mapped I/O block with debounced buttons and LED regs
// Revision: 1.0
// ---------------------------------------------------------------------------
module io_controller
    import io_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [7:0] BASE_ADDR       = 8'h00,
    parameter int         CNT_W           = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    io_controller_if.slave   bus,
    input  wire logic        bc,
    input  wire logic        bac,
    output logic [7:0]       led_x,
    output logic [7:0]       led_y,
    output logic             dbg_valid,
    output logic [7:0]       dbg_data,
    output logic             irq
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [7:0]       w_offs;
    logic [2:0]       w_reg;
    logic             w_sel;
    logic             w_is_rd;
    logic             w_start;
    logic             w_commit;
    logic             w_exit;
    logic             w_clr;
    logic             w_bc_db;
    logic             w_bac_db;
    logic             w_cw_ev;
    logic             w_ccw_ev;
    logic [CNT_W-1:0] w_cw_nxt;
    logic [CNT_W-1:0] w_ccw_nxt;
    logic [7:0]       w_rdata;
    acc_state_t       w_state_nxt;

    acc_state_t       r_state;
    logic             r_first;
    logic             r_clr_pend;
    logic [7:0]       r_led_x;
    logic [7:0]       r_led_y;
    logic [1:0]       r_ctrl;
    logic [7:0]       r_dbg_data;
    logic             r_dbg_valid;
    logic             r_irq;
    logic [CNT_W-1:0] r_cw_cnt;
    logic [CNT_W-1:0] r_ccw_cnt;

    // Unsigned wrap makes addresses below the base fall outside the window.
    assign w_offs  = bus.addr - BASE_ADDR;
    assign w_reg   = w_offs[2:0];
    assign w_sel   = bus.mem_io & bus.mem_clk & (w_offs < NUM_REGS);
    assign w_is_rd = bus.io_oe & ~bus.io_we;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bc (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn   (bc),
        .o_level (w_bc_db),
        .o_rise  (w_cw_ev)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bac (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn   (bac),
        .o_level (w_bac_db),
        .o_rise  (w_ccw_ev)
    );

    // A strobe already high out of reset goes straight to RELEASE with no side effects.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_sel) w_state_nxt = r_first ? ST_RELEASE : ST_ACCESS;
            ST_ACCESS:  w_state_nxt = w_sel ? ST_RELEASE : ST_IDLE;
            ST_RELEASE: w_state_nxt = w_sel ? ST_RELEASE : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_start  = (r_state == ST_IDLE) & w_sel & ~r_first;
    assign w_commit = w_start & bus.io_we;
    assign w_exit   = (r_state != ST_IDLE) & ~w_sel;
    assign w_clr    = w_exit & r_clr_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_first    <= 1'b1;
            r_clr_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= 1'b0;
            if (w_start) begin
                r_clr_pend <= w_is_rd & (w_reg == OFF_EVENT);
            end else if (w_exit) begin
                r_clr_pend <= 1'b0;
            end
        end
    end

    // Clear happens first so an event on the clear edge still counts as one.
    always_comb begin
        w_cw_nxt  = r_cw_cnt;
        w_ccw_nxt = r_ccw_cnt;
        if (w_clr) begin
            w_cw_nxt  = CNT_W'(w_cw_ev);
            w_ccw_nxt = CNT_W'(w_ccw_ev);
        end else begin
            if (w_cw_ev && (r_cw_cnt != C_CNT_MAX))   w_cw_nxt  = r_cw_cnt + 1'b1;
            if (w_ccw_ev && (r_ccw_cnt != C_CNT_MAX)) w_ccw_nxt = r_ccw_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led_x     <= 8'h01;
            r_led_y     <= 8'h00;
            r_ctrl      <= 2'b00;
            r_dbg_data  <= 8'h00;
            r_dbg_valid <= 1'b0;
            r_irq       <= 1'b0;
            r_cw_cnt    <= '0;
            r_ccw_cnt   <= '0;
        end else begin
            r_cw_cnt    <= w_cw_nxt;
            r_ccw_cnt   <= w_ccw_nxt;
            r_dbg_valid <= w_commit & (w_reg == OFF_DBG_OUT);
            r_irq       <= r_ctrl[CTRL_IRQ_EN] & ((r_cw_cnt != '0) | (r_ccw_cnt != '0));

            if (w_commit && (w_reg == OFF_DBG_OUT)) r_dbg_data <= bus.data_in;
            if (w_commit && (w_reg == OFF_LED_Y))   r_led_y    <= bus.data_in;
            if (w_commit && (w_reg == OFF_CTRL))    r_ctrl     <= bus.data_in[1:0];

            if (w_commit && (w_reg == OFF_LED_X)) begin
                r_led_x <= bus.data_in;
            end else if (r_ctrl[CTRL_AUTO_STEP] && (w_cw_ev != w_ccw_ev)) begin
                r_led_x <= w_cw_ev ? rotl8(r_led_x) : rotr8(r_led_x);
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (w_sel) begin
            case (w_reg)
                OFF_BTN_STATUS: w_rdata = {6'b0, w_bc_db, w_bac_db};
                OFF_LED_X:      w_rdata = r_led_x;
                OFF_LED_Y:      w_rdata = r_led_y;
                OFF_EVENT:      w_rdata = {4'(r_cw_cnt), 4'(r_ccw_cnt)};
                OFF_CTRL:       w_rdata = {6'b0, r_ctrl};
                default:        w_rdata = 8'h00;
            endcase
        end
    end

    assign bus.data_out = w_rdata;
    assign bus.data_oe  = w_sel & w_is_rd;

    assign led_x     = r_led_x;
    assign led_y     = r_led_y;
    assign dbg_valid = r_dbg_valid;
    assign dbg_data  = r_dbg_data;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_io_controller : scoreboard bench for io_controller (DEBOUNCE_CYCLES=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_io_controller;

    localparam logic [7:0] BASE = 8'h40;

    logic       clk;
    logic       reset;
    logic       bc;
    logic       bac;
    logic [7:0] led_x;
    logic [7:0] led_y;
    logic       dbg_valid;
    logic [7:0] dbg_data;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_rd[$];
    logic [7:0] q_dbg[$];

    io_controller_if bus();

    io_controller #(
        .DEBOUNCE_CYCLES (4),
        .BASE_ADDR       (BASE),
        .CNT_W           (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .bc        (bc),
        .bac       (bac),
        .led_x     (led_x),
        .led_y     (led_y),
        .dbg_valid (dbg_valid),
        .dbg_data  (dbg_data),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_clk = 1'b0;
        bus.mem_io  = 1'b0;
        bus.io_we   = 1'b0;
        bus.io_oe   = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        if (a == BASE) q_dbg.push_back(d);
        bus.addr    = a;
        bus.data_in = d;
        bus.mem_io  = 1'b1;
        bus.io_we   = 1'b1;
        bus.io_oe   = 1'b0;
        bus.mem_clk = 1'b1;
        tick(hold);
        bus_idle();
        tick(1);
    endtask

    task automatic io_read(input logic [7:0] a, input logic [7:0] exp, input int hold, input logic with_bc);
        q_rd.push_back(exp);
        bus.addr    = a;
        bus.mem_io  = 1'b1;
        bus.io_we   = 1'b0;
        bus.io_oe   = 1'b1;
        bus.mem_clk = 1'b1;
        if (with_bc) bc = 1'b1;
        tick(hold);
        bus_idle();
        tick(1);
    endtask

    task automatic read_outside(input logic [7:0] a);
        bus.addr    = a;
        bus.mem_io  = 1'b1;
        bus.io_oe   = 1'b1;
        bus.mem_clk = 1'b1;
        @(negedge clk);
        check("oe_outside", {7'b0, bus.data_oe}, 8'h00);
        @(posedge clk); #1;
        bus_idle();
        tick(1);
    endtask

    task automatic press(input logic cw, input logic ccw);
        bc  = cw;
        bac = ccw;
        tick(8);
        bc  = 1'b0;
        bac = 1'b0;
        tick(8);
    endtask

    // Monitor: pops one expected read value per strobe and holds it while data_oe stays high.
    initial begin : monitor
        logic       prev_oe;
        logic       cur_valid;
        logic [7:0] cur_exp;
        prev_oe   = 1'b0;
        cur_valid = 1'b0;
        cur_exp   = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.data_oe === 1'b1) begin
                if (!prev_oe) begin
                    if (q_rd.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        cur_valid = 1'b0;
                        $display("FAIL unexpected_read: data_oe with data %h, nothing expected", bus.data_out);
                    end else begin
                        cur_exp   = q_rd.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) check("read_data", bus.data_out, cur_exp);
            end
            prev_oe = (bus.data_oe === 1'b1);
            if (dbg_valid === 1'b1) begin
                if (q_dbg.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_dbg_valid: data %h, no pulse expected", dbg_data);
                end else begin
                    check("dbg_data", dbg_data, q_dbg.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        reset       = 1'b0;
        bc          = 1'b0;
        bac         = 1'b0;
        bus.addr    = 8'h00;
        bus.data_in = 8'h00;
        bus_idle();
        tick(3);
        reset = 1'b1;
        tick(1);

        check("rst_led_x",     led_x,              8'h01);
        check("rst_led_y",     led_y,              8'h00);
        check("rst_irq",       {7'b0, irq},        8'h00);
        check("rst_dbg_valid", {7'b0, dbg_valid},  8'h00);
        check("rst_dbg_data",  dbg_data,           8'h00);
        read_outside(BASE - 8'd1);
        read_outside(BASE + 8'd6);
        read_outside(8'h00);
        io_read(BASE + 8'd2, 8'h01, 2, 1'b0);
        io_read(BASE + 8'd5, 8'h00, 1, 1'b0);
        io_read(BASE + 8'd4, 8'h00, 1, 1'b0);
        io_read(BASE + 8'd0, 8'h00, 1, 1'b0);

        // Register writes
        io_write(BASE + 8'd0, 8'h2A, 3);
        tick(2);
        check("dbg_data_held", dbg_data, 8'h2A);
        io_write(BASE + 8'd3, 8'h5C, 2);
        io_read(BASE + 8'd3, 8'h5C, 3, 1'b0);
        io_write(BASE + 8'd2, 8'h33, 1);
        io_read(BASE + 8'd2, 8'h33, 1, 1'b0);
        io_write(BASE + 8'd5, 8'hFF, 1);
        io_read(BASE + 8'd5, 8'h03, 1, 1'b0);
        io_write(BASE + 8'd5, 8'h00, 1);
        io_write(BASE + 8'd6, 8'hEE, 1);
        io_read(BASE + 8'd3, 8'h5C, 1, 1'b0);

        // Read and write together is a write with the bus undriven
        bus.addr    = BASE + 8'd3;
        bus.data_in = 8'h77;
        bus.mem_io  = 1'b1;
        bus.io_we   = 1'b1;
        bus.io_oe   = 1'b1;
        bus.mem_clk = 1'b1;
        @(negedge clk);
        check("oe_we_both", {7'b0, bus.data_oe}, 8'h00);
        @(posedge clk); #1;
        bus_idle();
        tick(1);
        io_read(BASE + 8'd3, 8'h77, 1, 1'b0);

        // Debounce latency, observed through BTN_STATUS with io_oe low
        bus.addr    = BASE + 8'd1;
        bus.mem_io  = 1'b1;
        bus.mem_clk = 1'b1;
        bc          = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("btn_latency_%0d", k), bus.data_out, (k >= 6) ? 8'h02 : 8'h00);
        end
        #1;
        bus_idle();
        bc = 1'b0;
        tick(10);
        bac = 1'b1;
        tick(3);
        bac = 1'b0;
        tick(10);
        io_read(BASE + 8'd1, 8'h00, 1, 1'b0);
        io_read(BASE + 8'd4, 8'h10, 2, 1'b0);
        io_read(BASE + 8'd4, 8'h00, 1, 1'b0);

        // Saturation and clear-on-read
        for (int p = 0; p < 17; p++) press(1'b1, 1'b0);
        io_read(BASE + 8'd4, 8'hF0, 2, 1'b0);
        io_read(BASE + 8'd4, 8'h00, 1, 1'b0);
        io_read(BASE + 8'd4, 8'h00, 6, 1'b1);
        bc = 1'b0;
        tick(10);
        io_read(BASE + 8'd4, 8'h10, 1, 1'b0);

        // Auto-step rotation and irq
        io_write(BASE + 8'd2, 8'h01, 1);
        io_write(BASE + 8'd5, 8'h03, 1);
        press(1'b1, 1'b0);
        check("rot_cw", led_x, 8'h02);
        check("irq_set", {7'b0, irq}, 8'h01);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("rot_ccw_wrap", led_x, 8'h80);
        press(1'b1, 1'b1);
        check("rot_both", led_x, 8'h80);
        bc = 1'b1;
        tick(6);
        io_write(BASE + 8'd2, 8'h55, 1);
        bc = 1'b0;
        tick(10);
        check("cpu_wins_rot", led_x, 8'h55);
        io_read(BASE + 8'd4, 8'h33, 1, 1'b0);
        tick(2);
        check("irq_cleared", {7'b0, irq}, 8'h00);

        // Reset in the middle of a LED_X write strobe
        bus.addr    = BASE + 8'd2;
        bus.data_in = 8'h99;
        bus.mem_io  = 1'b1;
        bus.io_we   = 1'b1;
        bus.mem_clk = 1'b1;
        tick(1);
        check("ledx_written", led_x, 8'h99);
        reset = 1'b0;
        #1;
        check("ledx_async_rst", led_x, 8'h01);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("ledx_no_rewrite", led_x, 8'h01);
        bus.mem_clk = 1'b0;
        tick(2);
        bus.mem_clk = 1'b1;
        tick(1);
        check("ledx_new_strobe", led_x, 8'h99);
        bus_idle();
        tick(3);

        check("rd_queue_empty",  8'(q_rd.size()),  8'h00);
        check("dbg_queue_empty", 8'(q_dbg.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_controller.md
Name: io_controller

Overview:
- Memory-mapped I/O controller on the CPU's I/O cycles (mem_io qualified by mem_clk); replaces the ad-hoc debug I/O logic and button latch in the machine top level.
- Synchronises and debounces the clockwise (bc) and anticlockwise (bac) buttons, and counts their press events.
- Owns the led_x/led_y output registers and can auto-rotate led_x on button events.
- Sequences each I/O access so side effects happen exactly once per strobe.

Parameters:
- DEBOUNCE_CYCLES, 16: clk cycles a synchronised button level must be stable before it is accepted (>=2).
- BASE_ADDR, 8'h00: I/O address of register 0; registers occupy BASE_ADDR..BASE_ADDR+5.
- CNT_W, 4: width of each saturating event counter.

Ports:
- clk, input, 1: system clock; all state on its rising edge.
- reset, input, 1: asynchronous, active-low reset; the clock is clk and the reset is reset, asynchronous and active-low.
- mem_clk, input, 1: CPU memory strobe, synchronous to clk.
- mem_io, input, 1: cycle is I/O (not RAM).
- io_we, input, 1: CPU writes (c_ri).
- io_oe, input, 1: CPU reads (c_ro).
- addr, input, 8: I/O address (addr_bus).
- data_in, input, 8: bus value during writes.
- data_out, output, 8: read data.
- data_oe, output, 1: top level drives bus with data_out when 1, else Z.
- bc, input, 1: clockwise button, asynchronous.
- bac, input, 1: anticlockwise button, asynchronous.
- led_x, output, 8: LED X register.
- led_y, output, 8: LED Y register.
- dbg_valid, output, 1: one-cycle pulse on a DBG_OUT write.
- dbg_data, output, 8: last DBG_OUT value.
- irq, output, 1: event pending and interrupt enabled.

Behaviour:
- Strobe: sel = mem_io & mem_clk & addr in [BASE_ADDR, BASE_ADDR+5].
- Register map (offset from BASE_ADDR):
  - 0 DBG_OUT: write-only; reads 0.
  - 1 BTN_STATUS: read-only; {6'b0, bc_db, bac_db}.
  - 2 LED_X: read/write.
  - 3 LED_Y: read/write.
  - 4 EVENT: read, clear-on-read; {cw_cnt, ccw_cnt}, 4 bits each.
  - 5 CTRL: read/write; bit0 auto_step, bit1 irq_en; bits 7:2 read 0, writes ignored.
- Access FSM, states IDLE, ACCESS, RELEASE:
  - IDLE->ACCESS on first clk with sel=1. Write side effects commit on this edge: register update, dbg_valid pulse.
  - ACCESS->RELEASE next clk while sel stays 1; ACCESS->IDLE if sel drops.
  - RELEASE holds until sel=0, then IDLE. Clear-on-read of EVENT commits on the exit edge to IDLE, so read data stays stable for the whole strobe.
  - Result: exactly one write/clear per strobe, regardless of strobe length.
- data_oe = sel & io_oe & ~io_we. data_out is a combinational mux of registered state; 0 when not selected.
- io_we and io_oe both 1: treated as a write; data_oe=0.
- Addresses outside the window: no effect, data_oe=0.
- Buttons, per input:
  - 2-flop synchroniser, then debounce counter.
  - Debounced level changes after DEBOUNCE_CYCLES consecutive cycles of a stable differing synchronised value. Any glitch restarts the count.
  - A rising edge of the debounced level is a one-cycle event. Latency from pin to event = 2 + DEBOUNCE_CYCLES clk cycles.
- Event counters:
  - Saturate at 2^CNT_W-1 (15); no wrap.
  - Event in the same cycle as a clear-on-read: result is 1, i.e. clear then increment; the event is not lost.
- Auto-step (CTRL.auto_step=1): cw event rotates led_x left by 1 (8'h80->8'h01); ccw event rotates right (8'h01->8'h80).
- Simultaneous cases:
  - cw and ccw events in the same cycle: both counters increment, no rotation.
  - CPU write to LED_X in the same cycle as a rotation: the CPU write wins.
- irq = irq_en & (cw_cnt != 0 | ccw_cnt != 0); registered, one-cycle latency.
- Reset values:
  - led_x=8'h01, led_y=8'h00, dbg_data=0, dbg_valid=0, CTRL=0.
  - Counters 0, debounced levels 0, synchronisers 0, FSM=IDLE, irq=0.
- Reset mid-access: everything returns to reset values immediately. A strobe still high after reset release is not a new access until it drops and rises again (FSM enters RELEASE if sel is high on the first cycle after reset).

Decomposition:
- Package io_pkg: register offset constants (DBG_OUT..CTRL), CTRL bit indices, FSM state enum.
- Sub-module button_debounce: synchroniser, debounce counter, rising-edge pulse output; instantiated twice (bc, bac).

Test Plan:
- Reset, no activity -> led_x=8'h01, led_y=0, irq=0, data_oe=0 for all reads outside the window.
- I/O write 8'h2A to offset 0 with strobe held 3 cycles -> exactly one dbg_valid pulse, dbg_data=8'h2A. Write 8'h5C to LED_Y -> read returns 8'h5C.
- bc held high, DEBOUNCE_CYCLES=4 -> BTN_STATUS bit1 rises 6 cycles after pin. A 3-cycle glitch produces no event and no status change.
- 17 bc presses, no read -> EVENT reads 8'hF0. After the strobe ends, EVENT reads 8'h00. Press landing on the clear edge -> EVENT=8'h10.
- CTRL=8'h03, one bc press -> led_x 8'h01->8'h02, irq=1. bac twice -> led_x=8'h80. bc and bac in the same cycle -> led_x unchanged.
- Assert reset mid-strobe during a LED_X write -> led_x=8'h01. Strobe still high after reset release -> no write until it toggles.
